// File: rtl/qsys_cpu_cpu_debug_scan_pkg.sv
// Shared types and constants for the virtual-JTAG debug scan master.
package qsys_cpu_cpu_debug_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SDR,
    S_UDR,
    S_RTI,
    S_DONE
  } state_e;

  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  localparam int DR_LEN_DEF = 38;

  // Strobe pattern {uir, cdr, sdr, udr, rti} for a given state.
  function automatic logic [4:0] vji_strobes(state_e s);
    logic [4:0] v;
    v = '0;
    case (s)
      S_UIR:   v = 5'b10000;
      S_CDR:   v = 5'b01000;
      S_SDR:   v = 5'b00100;
      S_UDR:   v = 5'b00010;
      S_RTI:   v = 5'b00001;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/qsys_cpu_cpu_debug_scan_tckgen.sv
// TCK divider: square wave starting low, with one-cycle
// strobes on the clk cycle just before each tck edge.
module qsys_cpu_cpu_debug_scan_tckgen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic rise,
  output logic fall
);

  logic [7:0] div;
  logic       last;

  assign last = (div == 8'(TCK_DIV - 1));
  assign rise = en & last & ~tck;
  assign fall = en & last & tck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      div <= '0;
      tck <= 1'b0;
    end else if (last) begin
      div <= '0;
      tck <= ~tck;
    end else begin
      div <= div + 8'd1;
    end
  end

endmodule

// File: rtl/qsys_cpu_cpu_debug_scan_master.sv
// Debug scan master: walks the virtual TAP through
// UIR/CDR/SDR/UDR/RTI for one command at a time.
module qsys_cpu_cpu_debug_scan_master
  import qsys_cpu_cpu_debug_scan_pkg::*;
#(
  parameter int TCK_DIV = 4,
  parameter int DR_LEN  = DR_LEN_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_ir,
  input  logic [DR_LEN-1:0] cmd_dr,
  output logic              rsp_valid,
  output logic [DR_LEN-1:0] rsp_dr,
  output logic [1:0]        rsp_ir,
  output logic              vji_tck,
  output logic              vji_tdi,
  output logic [1:0]        vji_ir_in,
  output logic              vji_uir,
  output logic              vji_cdr,
  output logic              vji_sdr,
  output logic              vji_udr,
  output logic              vji_rti,
  input  logic              vji_tdo,
  input  logic [1:0]        vji_ir_out
);

  localparam int CW = $clog2(DR_LEN + 1);

  state_e            state;
  logic [DR_LEN-1:0] sr;
  logic [CW-1:0]     bit_cnt;
  logic [4:0]        stb;
  logic              tck_en;
  logic              tck_rise;
  logic              tck_fall;

  assign tck_en = (state != S_IDLE) && (state != S_DONE);
  assign {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} = stb;

  qsys_cpu_cpu_debug_scan_tckgen #(
    .TCK_DIV (TCK_DIV)
  ) u_tckgen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (tck_en),
    .tck     (vji_tck),
    .rise    (tck_rise),
    .fall    (tck_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      stb       <= '0;
      sr        <= '0;
      bit_cnt   <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_dr    <= '0;
      rsp_ir    <= '0;
      vji_tdi   <= 1'b0;
      vji_ir_in <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            sr        <= cmd_dr;
            vji_ir_in <= cmd_ir;
            cmd_ready <= 1'b0;
            state     <= S_UIR;
            stb       <= vji_strobes(S_UIR);
          end
        end
        S_UIR: begin
          if (tck_fall) begin
            rsp_ir <= vji_ir_out;
            state  <= S_CDR;
            stb    <= vji_strobes(S_CDR);
          end
        end
        S_CDR: begin
          if (tck_fall) begin
            vji_tdi <= sr[0];
            state   <= S_SDR;
            stb     <= vji_strobes(S_SDR);
          end
        end
        S_SDR: begin
          // Capture on tck rise, present the next bit on tck fall.
          if (tck_rise)
            sr <= {vji_tdo, sr[DR_LEN-1:1]};
          if (tck_fall) begin
            if (bit_cnt == CW'(DR_LEN - 1)) begin
              bit_cnt <= '0;
              vji_tdi <= 1'b0;
              state   <= S_UDR;
              stb     <= vji_strobes(S_UDR);
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
              vji_tdi <= sr[0];
            end
          end
        end
        S_UDR: begin
          if (tck_fall) begin
            state <= S_RTI;
            stb   <= vji_strobes(S_RTI);
          end
        end
        S_RTI: begin
          if (tck_fall) begin
            rsp_dr    <= sr;
            rsp_valid <= 1'b1;
            vji_ir_in <= '0;
            state     <= S_DONE;
            stb       <= '0;
          end
        end
        S_DONE: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          stb   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qsys_cpu_cpu_debug_scan_master.sv
// Randomized bench for the debug scan master, checked
// against a scan-level model of timing and data.
module tb_qsys_cpu_cpu_debug_scan_master;

  localparam int L       = 38;
  localparam int D       = 4;
  localparam int LAT     = 1 + (L + 4) * 2 * D;
  localparam int LAT1    = 1 + (L + 4) * 2;
  localparam int SDR_CYC = L * 2 * D;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;

  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_ir = '0;
  logic [L-1:0] cmd_dr = '0;
  logic         rsp_valid;
  logic [L-1:0] rsp_dr;
  logic [1:0]   rsp_ir;
  logic         vji_tck, vji_tdi;
  logic [1:0]   vji_ir_in;
  logic         vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic         vji_tdo;
  logic [1:0]   vji_ir_out = '0;
  logic         loop_mode = 1'b1;
  logic         tdo_drv = 1'b0;
  logic [49:0]  dut_outs;

  logic         c1_valid = 1'b0;
  logic         c1_ready;
  logic [1:0]   c1_ir = '0;
  logic [L-1:0] c1_dr = '0;
  logic         r1_valid;
  logic [L-1:0] r1_dr;
  logic [1:0]   r1_ir;
  logic         tck1, tdi1;
  logic [1:0]   ir_in1;
  logic         uir1, cdr1, sdr1, udr1, rti1;
  logic [1:0]   ir_out1 = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign vji_tdo = loop_mode ? vji_tdi : tdo_drv;
  assign dut_outs = {rsp_valid, rsp_dr, rsp_ir, vji_tck, vji_tdi,
                     vji_ir_in, vji_uir, vji_cdr, vji_sdr,
                     vji_udr, vji_rti};

  qsys_cpu_cpu_debug_scan_master dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ir     (cmd_ir),
    .cmd_dr     (cmd_dr),
    .rsp_valid  (rsp_valid),
    .rsp_dr     (rsp_dr),
    .rsp_ir     (rsp_ir),
    .vji_tck    (vji_tck),
    .vji_tdi    (vji_tdi),
    .vji_ir_in  (vji_ir_in),
    .vji_uir    (vji_uir),
    .vji_cdr    (vji_cdr),
    .vji_sdr    (vji_sdr),
    .vji_udr    (vji_udr),
    .vji_rti    (vji_rti),
    .vji_tdo    (vji_tdo),
    .vji_ir_out (vji_ir_out)
  );

  qsys_cpu_cpu_debug_scan_master #(.TCK_DIV(1)) dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (c1_valid),
    .cmd_ready  (c1_ready),
    .cmd_ir     (c1_ir),
    .cmd_dr     (c1_dr),
    .rsp_valid  (r1_valid),
    .rsp_dr     (r1_dr),
    .rsp_ir     (r1_ir),
    .vji_tck    (tck1),
    .vji_tdi    (tdi1),
    .vji_ir_in  (ir_in1),
    .vji_uir    (uir1),
    .vji_cdr    (cdr1),
    .vji_sdr    (sdr1),
    .vji_udr    (udr1),
    .vji_rti    (rti1),
    .vji_tdo    (tdi1),
    .vji_ir_out (ir_out1)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [L-1:0] rnd_dr();
    return L'({$urandom(), $urandom()});
  endfunction

  // One full scan on the default DUT; busy-time cmd_valid is random.
  task automatic run_scan(input logic [1:0] ir, input logic [L-1:0] dr,
                          input logic lb, input logic [L-1:0] pat,
                          input logic [1:0] irout);
    int lat = -1;
    int sdr_n = 0;
    int k = 0;
    int bad = 0;
    int tdi_bad = 0;
    int irin_bad = 0;
    logic prev_tck = 1'b0;
    logic [4:0] s;
    logic [L-1:0] exp_dr;
    exp_dr = lb ? dr : pat;
    @(negedge clk);
    check("ready_idle", 64'(cmd_ready), 64'd1);
    cmd_ir = ir;
    cmd_dr = dr;
    cmd_valid = 1'b1;
    loop_mode = lb;
    tdo_drv = pat[0];
    @(posedge clk);
    for (int c = 1; c <= 4 * LAT; c++) begin
      @(negedge clk);
      s = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};
      if ($countones(s) > 1) bad++;
      if (s == 5'd0 && vji_tck) bad++;
      if (cmd_ready) bad++;
      if (vji_ir_in !== ((s != 5'd0) ? ir : 2'd0)) irin_bad++;
      if (vji_sdr) sdr_n++;
      if (!vji_sdr && vji_tdi) tdi_bad++;
      if (vji_sdr && vji_tck && !prev_tck) begin
        if (k >= L || vji_tdi !== dr[k]) tdi_bad++;
        k++;
        if (k < L) tdo_drv = pat[k];
      end
      prev_tck = vji_tck;
      vji_ir_out = vji_uir ? irout : 2'($urandom());
      if (rsp_valid) begin
        lat = c;
        cmd_valid = 1'b0;
        break;
      end
      cmd_valid = 1'($urandom());
      cmd_ir = 2'($urandom());
      cmd_dr = rnd_dr();
    end
    check("latency", 64'(lat), 64'(LAT));
    check("rsp_dr", 64'(rsp_dr), 64'(exp_dr));
    check("rsp_ir", 64'(rsp_ir), 64'(irout));
    check("sdr_cycles", 64'(sdr_n), 64'(SDR_CYC));
    check("tdi_bits", 64'(k), 64'(L));
    check("tdi_bad", 64'(tdi_bad), 64'd0);
    check("ir_in", 64'(irin_bad), 64'd0);
    check("protocol", 64'(bad), 64'd0);
    @(negedge clk);
    check("pulse_1cyc", 64'(rsp_valid), 64'd0);
    check("ready_after", 64'(cmd_ready), 64'd1);
    check("rsp_hold", 64'(rsp_dr), 64'(exp_dr));
  endtask

  // TCK_DIV=1 instance, always in loopback.
  task automatic run_div1(input logic [L-1:0] dr);
    int lat = -1;
    int bad = 0;
    logic prev = 1'b0;
    logic [4:0] s;
    @(negedge clk);
    c1_valid = 1'b1;
    c1_dr = dr;
    c1_ir = 2'($urandom());
    @(posedge clk);
    for (int c = 1; c <= 4 * LAT1; c++) begin
      @(negedge clk);
      c1_valid = 1'b0;
      s = {uir1, cdr1, sdr1, udr1, rti1};
      if (s != 5'd0 && c > 1 && tck1 == prev) bad++;
      prev = tck1;
      if (r1_valid) begin
        lat = c;
        break;
      end
    end
    check("div1_latency", 64'(lat), 64'(LAT1));
    check("div1_rsp_dr", 64'(r1_dr), 64'(dr));
    check("div1_toggle", 64'(bad), 64'd0);
  endtask

  task automatic run_stream();
    logic [L-1:0] q[$];
    int acc = 0;
    int rsp = 0;
    int last_acc = -1;
    int gap_bad = 0;
    loop_mode = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1;
    for (int i = 0; i < 3 * (LAT + 1); i++) begin
      if (i > 0) @(negedge clk);
      if (rsp_valid) begin
        rsp++;
        if (q.size() > 0) check("stream_dr", 64'(rsp_dr), 64'(q.pop_front()));
        else gap_bad++;
      end
      cmd_dr = rnd_dr();
      cmd_ir = 2'($urandom());
      if (cmd_valid && cmd_ready) begin
        if (last_acc >= 0 && i - last_acc != LAT + 1) gap_bad++;
        last_acc = i;
        acc++;
        q.push_back(cmd_dr);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("stream_accepts", 64'(acc), 64'd3);
    check("stream_rsps", 64'(rsp), 64'd3);
    check("stream_gaps", 64'(gap_bad), 64'd0);
  endtask

  task automatic run_abort();
    int pulses = 0;
    @(negedge clk);
    loop_mode = 1'b1;
    cmd_dr = rnd_dr();
    cmd_ir = 2'd3;
    cmd_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check("abort_outs", 64'(dut_outs), 64'd0);
    check("abort_ready", 64'(cmd_ready), 64'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("release_outs", 64'(dut_outs), 64'd0);
    check("release_ready", 64'(cmd_ready), 64'd1);
    for (int c = 0; c < LAT + 20; c++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check("abort_no_rsp", 64'(pulses), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("por_outs", 64'(dut_outs), 64'd0);
    check("por_ready", 64'(cmd_ready), 64'd1);
    check("por_ready_div1", 64'(c1_ready), 64'd1);

    run_scan(2'd2, 38'h15_A5A5_A5A5, 1'b1, '0, 2'b01);
    run_scan(2'd0, '0, 1'b0, {L{1'b1}}, 2'b10);
    run_scan(2'd1, rnd_dr(), 1'b1, '0, 2'b11);
    repeat (5)
      run_scan(2'($urandom()), rnd_dr(), 1'($urandom()),
               rnd_dr(), 2'($urandom()));

    run_div1(38'h1);
    run_div1(rnd_dr());

    run_stream();
    run_abort();
    run_scan(2'($urandom()), rnd_dr(), 1'b0, rnd_dr(), 2'($urandom()));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
